// File: rtl/mag_pkg.sv
// Shared register map, bit masks and sequencer state encoding for the MMC34160PJ poller.
package mag_pkg;

  localparam logic [7:0] REG_XOUT   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h06;
  localparam logic [7:0] REG_CTRL0  = 8'h07;

  localparam logic [7:0] CTRL0_TM_M       = 8'h01;
  localparam logic [7:0] CTRL0_SET        = 8'h20;
  localparam logic [7:0] STATUS_MEAS_DONE = 8'h01;

  localparam logic [7:0] XYZ_LEN = 8'd6;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SET,
    ST_SETW,
    ST_IDLE,
    ST_TRIG,
    ST_POLL,
    ST_RDXYZ,
    ST_PUB
  } state_t;

  function automatic logic is_cmd_state(input state_t s);
    return (s == ST_SET) || (s == ST_TRIG) || (s == ST_POLL) || (s == ST_RDXYZ);
  endfunction

endpackage

// File: rtl/mag_poll_sequencer_rate_tick.sv
// Free-running divider producing a one-cycle strobe at RATE_HZ; clr restarts the period.
module rate_tick #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned RATE_HZ = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ / RATE_HZ > 1) ? CLK_HZ / RATE_HZ : 2;
  localparam int unsigned W   = $clog2(DIV);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == W'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == W'(DIV - 1));

endmodule

// File: rtl/mag_poll_sequencer.sv
// Autonomous MMC34160PJ sequencer: one-time SET, then periodic trigger / status poll /
// 6-byte XYZ burst, publishing one coherent sample through an i2c_master command port.
module mag_poll_sequencer
  import mag_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 50,
  parameter logic [6:0]  DEV_ADDR  = 7'h30,
  parameter int unsigned POLL_MAX  = 16,
  parameter int unsigned XACT_TO   = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        i2c_start,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_wr_data,
  output logic [7:0]  i2c_rd_len,
  output logic        i2c_rd_ready,
  input  logic        i2c_rd_valid,
  input  logic [7:0]  i2c_rd_data,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic [15:0] mag_x,
  output logic [15:0] mag_y,
  output logic [15:0] mag_z,
  output logic        sample_valid,
  output logic        err_nack,
  output logic        err_timeout
);

  localparam int unsigned TW = $clog2(XACT_TO + 1);
  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  state_t          state_q, state_d;
  logic            pend_q;
  logic [TW-1:0]   to_cnt_q;
  logic [PW-1:0]   poll_cnt_q;
  logic [2:0]      byte_idx_q;
  logic [5:0][7:0] shadow_q;
  logic            stat_done_q;
  logic            set_retry_q;

  logic sample_tick, ms_tick;
  logic issue, xact_done, xact_to, stat_now, xyz_full, poll_last;
  logic set_nack, set_to;

  rate_tick #(.CLK_HZ(CLK_HZ), .RATE_HZ(SAMPLE_HZ)) u_sample_tick (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .tick(sample_tick)
  );

  rate_tick #(.CLK_HZ(CLK_HZ), .RATE_HZ(1000)) u_settle_tick (
    .clk(clk), .rst_n(rst_n), .clr(state_q != ST_SETW), .tick(ms_tick)
  );

  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_rd_ready = 1'b1;

  // Completion flags also see a byte arriving in the done cycle itself.
  assign xact_done = pend_q && i2c_done;
  assign xact_to   = pend_q && !i2c_done && (to_cnt_q == TW'(XACT_TO - 1));
  assign stat_now  = stat_done_q || (i2c_rd_valid && ((i2c_rd_data & STATUS_MEAS_DONE) != '0));
  assign xyz_full  = (byte_idx_q == 3'd6) || ((byte_idx_q == 3'd5) && i2c_rd_valid);
  assign poll_last = (poll_cnt_q == PW'(POLL_MAX - 1));

  assign issue = is_cmd_state(state_q) && !pend_q && !i2c_busy &&
                 !((state_q == ST_SET) && set_retry_q && !sample_tick);
  assign i2c_start = issue;

  assign set_nack = xact_done && i2c_nack;
  assign set_to   = xact_to ||
                    (xact_done && !i2c_nack && (state_q == ST_POLL) && !stat_now && poll_last) ||
                    (xact_done && !i2c_nack && (state_q == ST_RDXYZ) && !xyz_full);

  always_comb begin
    i2c_reg_addr = '0;
    i2c_rw       = 1'b0;
    i2c_wr_data  = '0;
    i2c_rd_len   = '0;
    unique case (state_q)
      ST_SET:   begin i2c_reg_addr = REG_CTRL0;  i2c_wr_data = CTRL0_SET;  end
      ST_TRIG:  begin i2c_reg_addr = REG_CTRL0;  i2c_wr_data = CTRL0_TM_M; end
      ST_POLL:  begin i2c_reg_addr = REG_STATUS; i2c_rw = 1'b1; i2c_rd_len = 8'd1;    end
      ST_RDXYZ: begin i2c_reg_addr = REG_XOUT;   i2c_rw = 1'b1; i2c_rd_len = XYZ_LEN; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (!i2c_busy) state_d = ST_SET;
      ST_SET: begin
        if (xact_done)    state_d = i2c_nack ? ST_SET : ST_SETW;
        else if (xact_to) state_d = ST_IDLE;
      end
      ST_SETW:  if (ms_tick) state_d = ST_IDLE;
      ST_IDLE:  if (sample_tick && enable) state_d = ST_TRIG;
      ST_TRIG: begin
        if (xact_done)    state_d = i2c_nack ? ST_IDLE : ST_POLL;
        else if (xact_to) state_d = ST_IDLE;
      end
      ST_POLL: begin
        if (xact_done) begin
          if (i2c_nack)       state_d = ST_IDLE;
          else if (stat_now)  state_d = ST_RDXYZ;
          else if (poll_last) state_d = ST_IDLE;
        end else if (xact_to) begin
          state_d = ST_IDLE;
        end
      end
      ST_RDXYZ: begin
        if (xact_done)    state_d = (!i2c_nack && xyz_full) ? ST_PUB : ST_IDLE;
        else if (xact_to) state_d = ST_IDLE;
      end
      ST_PUB:   state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
    // Dropping enable lets the in-flight command finish, then parks without publishing.
    if (!enable && (xact_done || xact_to) &&
        ((state_q == ST_TRIG) || (state_q == ST_POLL) || (state_q == ST_RDXYZ)))
      state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      pend_q       <= 1'b0;
      to_cnt_q     <= '0;
      poll_cnt_q   <= '0;
      byte_idx_q   <= '0;
      shadow_q     <= '0;
      stat_done_q  <= 1'b0;
      set_retry_q  <= 1'b0;
      mag_x        <= '0;
      mag_y        <= '0;
      mag_z        <= '0;
      sample_valid <= 1'b0;
      err_nack     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_valid <= 1'b0;

      if (issue) begin
        pend_q      <= 1'b1;
        to_cnt_q    <= '0;
        byte_idx_q  <= '0;
        stat_done_q <= 1'b0;
      end else if (xact_done || xact_to) begin
        pend_q <= 1'b0;
      end else if (pend_q) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      if (pend_q && i2c_rd_valid) begin
        if (state_q == ST_POLL)
          stat_done_q <= ((i2c_rd_data & STATUS_MEAS_DONE) != '0);
        if ((state_q == ST_RDXYZ) && (byte_idx_q < 3'd6)) begin
          shadow_q[byte_idx_q] <= i2c_rd_data;
          byte_idx_q           <= byte_idx_q + 3'd1;
        end
      end

      if (state_q == ST_IDLE)
        poll_cnt_q <= '0;
      else if ((state_q == ST_POLL) && xact_done && !i2c_nack && !stat_now)
        poll_cnt_q <= poll_cnt_q + PW'(1);

      if (issue && (state_q == ST_SET))
        set_retry_q <= 1'b0;
      else if ((state_q == ST_SET) && set_nack)
        set_retry_q <= 1'b1;

      if (set_nack) err_nack    <= 1'b1;
      if (set_to)   err_timeout <= 1'b1;

      if (state_q == ST_PUB) begin
        mag_x        <= {shadow_q[1], shadow_q[0]};
        mag_y        <= {shadow_q[3], shadow_q[2]};
        mag_z        <= {shadow_q[5], shadow_q[4]};
        sample_valid <= 1'b1;
        err_nack     <= 1'b0;
        err_timeout  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mag_poll_sequencer.sv
// Directed bench for mag_poll_sequencer with a behavioural i2c_master/sensor model.
module tb_mag_poll_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        i2c_start;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic        i2c_rw;
  logic [7:0]  i2c_wr_data;
  logic [7:0]  i2c_rd_len;
  logic        i2c_rd_ready;
  logic        i2c_rd_valid = 1'b0;
  logic [7:0]  i2c_rd_data = 8'h00;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic [15:0] mag_x, mag_y, mag_z;
  logic        sample_valid, err_nack, err_timeout;

  mag_poll_sequencer #(
    .CLK_HZ(100_000), .SAMPLE_HZ(100), .DEV_ADDR(7'h30), .POLL_MAX(4), .XACT_TO(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .i2c_start(i2c_start), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_rw(i2c_rw), .i2c_wr_data(i2c_wr_data), .i2c_rd_len(i2c_rd_len),
    .i2c_rd_ready(i2c_rd_ready), .i2c_rd_valid(i2c_rd_valid), .i2c_rd_data(i2c_rd_data),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
    .sample_valid(sample_valid), .err_nack(err_nack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Sensor configuration, written only by the stimulus block.
  int unsigned cfg_zeros = 0;
  bit          cfg_nack_xyz = 1'b0;
  logic [7:0]  cfg_xyz [6] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};

  // Master/sensor model state and transaction log.
  logic [16:0] xlog [$];
  int unsigned status_reads = 0, xyz_reads = 0, viol = 0, addr_bad = 0, zeros_seen = 0;
  int unsigned k = 0, c_len = 0;
  bit          m_act = 1'b0, c_rw = 1'b0, c_nack = 1'b0, m_end;
  logic [7:0]  c_reg = 8'h00, c_stat = 8'h00;

  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    i2c_rd_valid = 1'b0;
    m_end = 1'b0;
    if (m_act) begin
      k++;
      if (i2c_start) viol++;
      i2c_busy = 1'b1;
      if (c_nack) begin
        if (k == 3) m_end = 1'b1;
      end else if (!c_rw) begin
        if (k == 4) m_end = 1'b1;
      end else begin
        if (k >= 2 && (k % 2) == 0 && (k / 2) <= c_len) begin
          i2c_rd_valid = 1'b1;
          i2c_rd_data  = (c_reg == 8'h06) ? c_stat : cfg_xyz[k/2-1];
        end
        if (k == 2 * c_len + 2) m_end = 1'b1;
      end
      if (m_end) begin
        i2c_done = 1'b1;
        i2c_nack = c_nack;
        i2c_busy = 1'b0;
        m_act    = 1'b0;
      end
    end else if (i2c_start) begin
      if (i2c_dev_addr !== 7'h30) addr_bad++;
      m_act  = 1'b1;
      k      = 0;
      c_rw   = i2c_rw;
      c_reg  = i2c_reg_addr;
      c_len  = int'(i2c_rd_len);
      c_nack = i2c_rw && (i2c_reg_addr == 8'h00) && cfg_nack_xyz;
      xlog.push_back({i2c_rw, i2c_reg_addr, i2c_rw ? i2c_rd_len : i2c_wr_data});
      if (!i2c_rw && i2c_reg_addr == 8'h07 && i2c_wr_data == 8'h01) zeros_seen = 0;
      if (i2c_rw && i2c_reg_addr == 8'h06) begin
        status_reads++;
        if (zeros_seen < cfg_zeros) begin
          c_stat = 8'h00;
          zeros_seen++;
        end else begin
          c_stat = 8'h01;
        end
      end
      if (i2c_rw && i2c_reg_addr == 8'h00) xyz_reads++;
    end
  end

  int unsigned sv_count = 0;
  always @(negedge clk) if (sample_valid === 1'b1) sv_count++;

  int unsigned n_vec = 0, n_err = 0;
  int unsigned base_sv, base_st, base_x, nlog;
  bit ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_sv(input int unsigned base, output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = (sv_count != base);
    end
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_start"},  i2c_start, 0);
    chk({p, "_reg"},    i2c_reg_addr, 0);
    chk({p, "_rw"},     i2c_rw, 0);
    chk({p, "_wdat"},   i2c_wr_data, 0);
    chk({p, "_rlen"},   i2c_rd_len, 0);
    chk({p, "_dev"},    i2c_dev_addr, 32'h30);
    chk({p, "_rdy"},    i2c_rd_ready, 1);
    chk({p, "_magx"},   mag_x, 0);
    chk({p, "_magy"},   mag_y, 0);
    chk({p, "_magz"},   mag_z, 0);
    chk({p, "_sv"},     sample_valid, 0);
    chk({p, "_enack"},  err_nack, 0);
    chk({p, "_etime"},  err_timeout, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    // 1: SET first, then trigger / status / burst and one publish.
    enable = 1'b1;
    rst_n  = 1'b1;
    base_sv = sv_count;
    wait_sv(base_sv, ok);
    chk("s1_seen", ok, 1);
    repeat (20) @(negedge clk);
    chk("s1_pulses", sv_count - base_sv, 1);
    chk("s1_nlog", xlog.size(), 4);
    chk("s1_log0", xlog[0], {1'b0, 8'h07, 8'h20});
    chk("s1_log1", xlog[1], {1'b0, 8'h07, 8'h01});
    chk("s1_log2", xlog[2], {1'b1, 8'h06, 8'h01});
    chk("s1_log3", xlog[3], {1'b1, 8'h00, 8'h06});
    chk("s1_magx", mag_x, 16'h1234);
    chk("s1_magy", mag_y, 16'h5678);
    chk("s1_magz", mag_z, 16'h9ABC);
    chk("s1_errs", {err_nack, err_timeout}, 0);

    // 2: three not-ready status reads, then ready.
    cfg_xyz = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cfg_zeros = 3;
    base_st = status_reads;
    base_sv = sv_count;
    wait_sv(base_sv, ok);
    chk("s2_seen", ok, 1);
    chk("s2_polls", status_reads - base_st, 4);
    chk("s2_magx", mag_x, 16'h2211);
    chk("s2_magy", mag_y, 16'h4433);
    chk("s2_magz", mag_z, 16'h6655);
    chk("s2_errs", {err_nack, err_timeout}, 0);

    // 3: status never ready -> poll exhaustion, then recovery.
    cfg_zeros = 255;
    base_st = status_reads;
    base_sv = sv_count;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (err_timeout === 1'b1);
    end
    chk("s3_to_seen", ok, 1);
    chk("s3_polls", status_reads - base_st, 4);
    chk("s3_nosv", sv_count - base_sv, 0);
    chk("s3_magx", mag_x, 16'h2211);
    chk("s3_magz", mag_z, 16'h6655);
    cfg_xyz = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    cfg_zeros = 0;
    base_sv = sv_count;
    wait_sv(base_sv, ok);
    chk("s3_retry_seen", ok, 1);
    chk("s3_retry_magx", mag_x, 16'h0001);
    chk("s3_retry_magy", mag_y, 16'h0002);
    chk("s3_retry_magz", mag_z, 16'h0003);
    chk("s3_retry_eto", err_timeout, 0);

    // 4: NACK on the XYZ burst, then a clean sample.
    cfg_nack_xyz = 1'b1;
    base_sv = sv_count;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (err_nack === 1'b1);
    end
    chk("s4_nack_seen", ok, 1);
    chk("s4_nosv", sv_count - base_sv, 0);
    chk("s4_magx", mag_x, 16'h0001);
    chk("s4_magy", mag_y, 16'h0002);
    cfg_nack_xyz = 1'b0;
    cfg_xyz = '{8'hFF, 8'hFF, 8'h00, 8'h80, 8'h01, 8'h00};
    base_sv = sv_count;
    wait_sv(base_sv, ok);
    chk("s4_good_seen", ok, 1);
    chk("s4_good_magx", mag_x, 16'hFFFF);
    chk("s4_good_magy", mag_y, 16'h8000);
    chk("s4_good_magz", mag_z, 16'h0001);
    chk("s4_good_enack", err_nack, 0);

    // 5a: enable dropped while polling.
    cfg_zeros = 255;
    base_st = status_reads;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (status_reads != base_st);
    end
    chk("s5_poll_seen", ok, 1);
    enable = 1'b0;
    base_sv = sv_count;
    nlog = xlog.size();
    repeat (2500) @(negedge clk);
    chk("s5_polls", status_reads - base_st, 1);
    chk("s5_nocmd", xlog.size(), nlog);
    chk("s5_nosv", sv_count - base_sv, 0);
    chk("s5_eto", err_timeout, 0);

    // 5b: one-cycle reset in the middle of the XYZ burst.
    cfg_zeros = 0;
    enable = 1'b1;
    base_x = xyz_reads;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (xyz_reads != base_x);
    end
    chk("s5_burst_seen", ok, 1);
    base_sv = sv_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("s5rst");
    nlog = xlog.size();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (xlog.size() != nlog);
    end
    chk("s5_restart_seen", ok, 1);
    chk("s5_restart_cmd", xlog[xlog.size()-1], {1'b0, 8'h07, 8'h20});
    chk("s5_restart_nosv", sv_count - base_sv, 0);
    chk("start_while_busy", viol, 0);
    chk("dev_addr_bad", addr_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
